// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage handshake between the pipeline and the multiply/divide sequencer
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, in1, in2, flush, input busy, stall, done, result);
  modport slave (input start, funct3, in1, in2, flush, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M shift-add multiply / restoring divide; MULDIV_EARLY_EXIT_EN skips CALC for trivial ops
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state, state_n;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   opb, ma, mb, q, r, res, rem_n;
  logic [XLEN:0]     sum, tmp;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              sa, sb, bz, sa_n, sb_n, is_div, ge, last, accept, skip;
`ifdef MULDIV_EARLY_EXIT_EN
  assign skip = is_div ? ((bus.in2 == '0) | (~bus.funct3[0] & (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.in2)))
                       : ((bus.in1 == '0) | (bus.in2 == '0));
`else
  assign skip = 1'b0;
`endif
  // operand magnitudes, one iteration step, and sign-corrected output selection
  always_comb begin
    is_div = bus.funct3[2];
    sa_n   = bus.in1[XLEN-1] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
    sb_n   = bus.in2[XLEN-1] & (is_div ? ~bus.funct3[0] : ~bus.funct3[1]);
    ma     = sa_n ? -bus.in1 : bus.in1;
    mb     = sb_n ? -bus.in2 : bus.in2;
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb & {XLEN{acc[0]}}};
    tmp    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge     = tmp >= {1'b0, opb};
    rem_n  = tmp[XLEN-1:0] - opb;
    prod   = (sa ^ sb) ? -acc : acc;
    q      = ((sa ^ sb) & ~bz) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r      = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res    = op[2] ? (op[1] ? r : q) : ((op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    last   = cnt == CNT_W'(XLEN-1);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    bus.busy  = state != IDLE;
    bus.stall = (state == CALC) | (state == FIX);
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        accept    = bus.start & ~bus.flush;
        bus.stall = accept;
        state_n   = accept ? (skip ? FIX : CALC) : IDLE;
      end
      CALC: state_n = bus.flush ? IDLE : (last ? FIX : CALC);
      FIX:  state_n = bus.flush ? IDLE : DONE;
      default: begin
        bus.done = ~bus.flush;
        state_n  = IDLE;
      end
    endcase
  end
  // operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op         <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      bz         <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      bus.result <= '0;
    end else begin
      if (accept) begin
        op  <= bus.funct3;
        sa  <= sa_n;
        sb  <= sb_n;
        bz  <= bus.in2 == '0;
        cnt <= '0;
        opb <= is_div ? mb : ma;
        acc <= (skip & ~is_div) ? '0 : (skip & (bus.in2 == '0)) ? {ma, {XLEN{1'b1}}} : {{XLEN{1'b0}}, is_div ? ma : mb};
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= op[2] ? {ge ? rem_n : tmp[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
      end
      if (state == FIX && !bus.flush) bus.result <= res;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for the RV32M multiply/divide sequencer
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last = '0;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam int LS = 2;
`else
  localparam int LS = 34;
`endif
  muldiv_seq_if bus ();
  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat);
    int n;
    logic st_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.in1 = a;
    bus.in2 = b;
    #1 st_ok = bus.stall;
    n = 0;
    for (int i = 0; i < 60 && n == 0; i++) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (bus.done) n = i + 1;
      else if (!bus.stall) st_ok = 1'b0;
    end
    chk({tag, "/lat"}, 32'(n), 32'(lat));
    chk({tag, "/res"}, bus.result, e);
    chk({tag, "/stall_busy"}, {31'b0, st_ok}, 32'd1);
    chk({tag, "/stall_done"}, {31'b0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "/pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "/held"}, bus.result, e);
    last = e;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = '0;
    bus.in1 = '0;
    bus.in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy", {31'b0, bus.busy}, 32'd0);
    chk("rst/done", {31'b0, bus.done}, 32'd0);
    chk("rst/res", bus.result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 34);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mul_zero", 3'b000, 32'd0, 32'd12345, 32'd0, LS);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_negb", 3'b100, 32'd20, 32'hFFFFFFFB, 32'hFFFFFFFC, 34);
    run_op("rem_negb", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    run_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, LS);
    run_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, LS);
    run_op("div0_neg", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LS);
    run_op("remu0", 3'b111, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LS);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LS);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LS);
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct3 = 3'b101;
    bus.in1 = 32'd9;
    bus.in2 = 32'd3;
    @(posedge clk);
    #1;
    chk("flush_idle/busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.in1 = 32'd100;
    bus.in2 = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_calc/busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_calc/done", {31'b0, bus.done}, 32'd0);
    chk("flush_calc/res", bus.result, last);
    run_op("after_flush", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.in1 = 32'd3;
    bus.in2 = 32'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst/busy", {31'b0, bus.busy}, 32'd0);
    chk("arst/done", {31'b0, bus.done}, 32'd0);
    chk("arst/res", bus.result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("after_rst", 3'b000, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 34);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
